// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - Philips I2S stereo receiver with valid/ready output (optional overrun flag: I2S_RX_OVERRUN_EN)
module i2s_rx #(
  parameter int DW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 lrclk,
  input  logic                 sdi,
  output logic signed [DW-1:0] l_sample,
  output logic signed [DW-1:0] r_sample,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun
);

  localparam int IW = $clog2(DW + 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(DW - 1);
  localparam logic [IW-1:0] IDX_SAT  = IW'(DW + 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [1:0] {UNLOCKED, LEFT, RIGHT} state_t;

  state_t          state, state_nxt;
  logic            sclk_q, sclk_qq, lrclk_q, sdi_q;
  logic            lr_prev;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   l_shift, r_shift;
  logic            left_done;
  logic            pair_done;

  logic            rise, lr_edge, shift_bit, word_end;
  logic            l_shift_en, r_shift_en, left_end, pair_load;

  // Word boundaries are only meaningful at sclk rising edges; the bit index
  // saturates past the LSB so long slots simply idle until lrclk toggles.
  assign rise      = sclk_q & ~sclk_qq;
  assign lr_edge   = rise & (lrclk_q != lr_prev);
  assign shift_bit = rise & ~lr_edge & (idx <= IDX_LAST);
  assign word_end  = shift_bit & (idx == IDX_LAST);

  // Register the serial inputs once, plus a second sclk stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q  <= 1'b0;
      sclk_qq <= 1'b0;
      lrclk_q <= 1'b0;
      sdi_q   <= 1'b0;
    end else begin
      sclk_q  <= sclk;
      sclk_qq <= sclk_q;
      lrclk_q <= lrclk;
      sdi_q   <= sdi;
    end
  end

  // Track lrclk at each bit and count bit position inside the current word.
  always_ff @(posedge clk) begin
    if (rst) begin
      lr_prev <= 1'b0;
      idx     <= '0;
    end else if (rise) begin
      lr_prev <= lrclk_q;
      if (lr_edge)
        idx <= '0;
      else if (idx != IDX_SAT)
        idx <= idx + IDX_ONE;
    end
  end

  // Frame lock state register.
  always_ff @(posedge clk) begin
    if (rst) state <= UNLOCKED;
    else     state <= state_nxt;
  end

  // Next-state logic and per-channel shift/complete strobes.
  always_comb begin
    state_nxt  = state;
    l_shift_en = 1'b0;
    r_shift_en = 1'b0;
    left_end   = 1'b0;
    pair_load  = 1'b0;
    case (state)
      UNLOCKED: begin
        if (lr_edge && !lrclk_q) state_nxt = LEFT;
      end
      LEFT: begin
        l_shift_en = shift_bit;
        left_end   = word_end;
        // A right-channel start before the left LSB means a short slot: resync.
        if (lr_edge) state_nxt = left_done ? RIGHT : UNLOCKED;
      end
      RIGHT: begin
        r_shift_en = shift_bit;
        pair_load  = word_end;
        if (lr_edge) state_nxt = LEFT;
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  // MSB-first shift registers, a left-complete flag and the pair-complete pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_shift   <= '0;
      r_shift   <= '0;
      left_done <= 1'b0;
      pair_done <= 1'b0;
    end else begin
      if (l_shift_en) l_shift <= {l_shift[DW-2:0], sdi_q};
      if (r_shift_en) r_shift <= {r_shift[DW-2:0], sdi_q};
      if (lr_edge)       left_done <= 1'b0;
      else if (left_end) left_done <= 1'b1;
      pair_done <= pair_load;
    end
  end

  // Output pair registers and valid handshake; a new pair always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_sample <= '0;
      r_sample <= '0;
      valid    <= 1'b0;
    end else if (pair_done) begin
      l_sample <= l_shift;
      r_sample <= r_shift;
      valid    <= 1'b1;
    end else if (valid && ready) begin
      valid    <= 1'b0;
    end
  end

`ifdef I2S_RX_OVERRUN_EN
  // Sticky flag: an unaccepted pair was overwritten.
  always_ff @(posedge clk) begin
    if (rst)
      overrun <= 1'b0;
    else if (pair_done && valid && !ready)
      overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - self-checking bench for i2s_rx with a frame-level reference model
module tb_i2s_rx;

  localparam int DW = 24;
`ifdef I2S_RX_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sclk;
  logic                 lrclk;
  logic                 sdi;
  logic                 ready;
  logic                 valid;
  logic                 overrun;
  logic signed [DW-1:0] l_sample;
  logic signed [DW-1:0] r_sample;

  int errors = 0;
  int checks = 0;

  logic [2*DW-1:0] got_q[$];
  int              valid_cycles = 0;

  i2s_rx #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .lrclk    (lrclk),
    .sdi      (sdi),
    .l_sample (l_sample),
    .r_sample (r_sample),
    .valid    (valid),
    .ready    (ready),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Record every accepted pair and every cycle valid is high.
  always @(negedge clk) begin
    if (!rst && valid) valid_cycles++;
    if (!rst && valid && ready) got_q.push_back({l_sample, r_sample});
  end

  // One sclk period: data and lrclk launched while sclk is low, 2+2 clk cycles.
  task automatic drive_bit(input logic lr, input logic d, input bit chk);
    sclk = 1'b0; lrclk = lr; sdi = d;
    repeat (2) begin @(posedge clk); #1; end
    sclk = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    if (chk) begin
      checks++;
      if (valid !== 1'b0) begin
        errors++; $display("FAIL latency_early: valid=%b expected 0", valid);
      end
      @(posedge clk); #1;
      checks++;
      if (valid !== 1'b1) begin
        errors++; $display("FAIL latency: valid=%b expected 1", valid);
      end
    end
  endtask

  // Half-frame of n bits: slot 0 is the delay bit, slots 1..DW carry MSB..LSB.
  task automatic drive_half(input logic lr, input logic [DW-1:0] w, input int n, input bit chk);
    logic b;
    for (int k = 0; k < n; k++) begin
      if (k >= 1 && k <= DW) b = w[DW-k];
      else                   b = 1'($urandom_range(0, 1));
      drive_bit(lr, b, chk && (k == DW));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int nl, input int nr, input bit chk);
    drive_half(1'b0, l, nl, 1'b0);
    drive_half(1'b1, r, nr, chk);
  endtask

  task automatic test_reset;
    rst = 1'b1; sclk = 1'b0; lrclk = 1'b0; sdi = 1'b0; ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (l_sample !== '0) begin errors++; $display("FAIL reset_l: got %h expected 0", l_sample); end
    checks++; if (r_sample !== '0) begin errors++; $display("FAIL reset_r: got %h expected 0", r_sample); end
    checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_basic;
    int base, vc0;
    rst = 1'b0; ready = 1'b1;
    drive_half(1'b1, DW'($urandom), 32, 1'b0);
    base = got_q.size(); vc0 = valid_cycles;
    send_frame(24'h123456, 24'hABCDEF, 32, 32, 1'b1);
    checks++;
    if (got_q.size() - base != 1) begin
      errors++; $display("FAIL basic_count: got %0d expected 1", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] !== {24'h123456, 24'hABCDEF}) begin
        errors++; $display("FAIL basic_pair: got %h expected %h", got_q[base], {24'h123456, 24'hABCDEF});
      end
    end
    checks++;
    if (int'(r_sample) != -5517841) begin
      errors++; $display("FAIL basic_signed: got %0d expected -5517841", int'(r_sample));
    end
    checks++;
    if (valid_cycles - vc0 != 1) begin
      errors++; $display("FAIL basic_valid_len: got %0d expected 1", valid_cycles - vc0);
    end
  endtask

  task automatic test_midframe;
    int base;
    rst = 1'b1;
    drive_half(1'b0, DW'($urandom), 32, 1'b0);
    for (int k = 0; k < 32; k++) begin
      if (k == 10) rst = 1'b0;
      drive_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end
    base = got_q.size();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL mid_novalid: got %b expected 0", valid); end
    send_frame(24'h000001, 24'h7FFFFF, 32, 32, 1'b0);
    checks++;
    if (got_q.size() - base != 1) begin
      errors++; $display("FAIL mid_count: got %0d expected 1", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] !== {24'h000001, 24'h7FFFFF}) begin
        errors++; $display("FAIL mid_pair: got %h expected %h", got_q[base], {24'h000001, 24'h7FFFFF});
      end
    end
  endtask

  task automatic test_backpressure;
    int base;
    ready = 1'b0;
    base = got_q.size();
    send_frame(24'h111111, 24'h222222, 32, 32, 1'b0);
    checks++; if (l_sample !== 24'h111111) begin errors++; $display("FAIL bp1_l: got %h expected 111111", l_sample); end
    checks++; if (r_sample !== 24'h222222) begin errors++; $display("FAIL bp1_r: got %h expected 222222", r_sample); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp1_valid: got %b expected 1", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp1_overrun: got %b expected 0", overrun); end
    send_frame(24'h333333, 24'h444444, 32, 32, 1'b0);
    checks++; if (l_sample !== 24'h333333) begin errors++; $display("FAIL bp2_l: got %h expected 333333", l_sample); end
    checks++; if (r_sample !== 24'h444444) begin errors++; $display("FAIL bp2_r: got %h expected 444444", r_sample); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp2_valid: got %b expected 1", valid); end
    checks++; if (overrun !== EXP_OVR) begin errors++; $display("FAIL bp2_overrun: got %b expected %b", overrun, EXP_OVR); end
    ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_accept: valid=%b expected 0", valid); end
    checks++;
    if (got_q.size() - base != 1) begin
      errors++; $display("FAIL bp_count: got %0d expected 1", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] !== {24'h333333, 24'h444444}) begin
        errors++; $display("FAIL bp_pair: got %h expected %h", got_q[base], {24'h333333, 24'h444444});
      end
    end
  endtask

  task automatic test_truncated;
    int base;
    logic [DW-1:0] l2, r2;
    ready = 1'b1;
    l2 = DW'($urandom); r2 = DW'($urandom);
    base = got_q.size();
    send_frame(DW'($urandom), DW'($urandom), 16, 32, 1'b0);
    checks++;
    if (got_q.size() != base) begin
      errors++; $display("FAIL trunc_drop: got %0d pairs expected 0", got_q.size() - base);
    end
    send_frame(l2, r2, 32, 32, 1'b0);
    checks++;
    if (got_q.size() - base != 1) begin
      errors++; $display("FAIL trunc_count: got %0d expected 1", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] !== {l2, r2}) begin
        errors++; $display("FAIL trunc_pair: got %h expected %h", got_q[base], {l2, r2});
      end
    end
  endtask

  task automatic test_reset_mid;
    int base;
    logic [DW-1:0] l2, r2;
    ready = 1'b0;
    send_frame(DW'($urandom), DW'($urandom), 32, 32, 1'b0);
    send_frame(DW'($urandom), DW'($urandom), 32, 32, 1'b0);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b expected 1", valid); end
    checks++; if (overrun !== EXP_OVR) begin errors++; $display("FAIL rm_pre_overrun: got %b expected %b", overrun, EXP_OVR); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (l_sample !== '0) begin errors++; $display("FAIL rm_l: got %h expected 0", l_sample); end
    checks++; if (r_sample !== '0) begin errors++; $display("FAIL rm_r: got %h expected 0", r_sample); end
    checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL rm_valid: got %b expected 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rm_overrun: got %b expected 0", overrun); end
    ready = 1'b1;
    l2 = DW'($urandom); r2 = DW'($urandom);
    base = got_q.size();
    drive_half(1'b1, DW'($urandom), 32, 1'b0);
    send_frame(l2, r2, 32, 32, 1'b0);
    checks++;
    if (got_q.size() - base != 1) begin
      errors++; $display("FAIL rm_resume_count: got %0d expected 1", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] !== {l2, r2}) begin
        errors++; $display("FAIL rm_resume_pair: got %h expected %h", got_q[base], {l2, r2});
      end
    end
  endtask

  task automatic test_random;
    logic [2*DW-1:0] exp_q[$];
    logic [DW-1:0]   l, r;
    int              base;
    ready = 1'b1;
    base = got_q.size();
    for (int f = 0; f < 8; f++) begin
      l = DW'($urandom); r = DW'($urandom);
      exp_q.push_back({l, r});
      send_frame(l, r, $urandom_range(DW + 1, 32), $urandom_range(DW + 1, 32), 1'b0);
    end
    checks++;
    if (got_q.size() - base != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[base + i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_pair%0d: got %h expected %h", i, got_q[base + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL rand_overrun: got %b expected 0", overrun); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_midframe;
    test_backpressure;
    test_truncated;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
